// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one radix-2 step per cycle, with flush abort.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [TAG_W-1:0] rd_in,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [2:0]          op_q, op_d;
  logic [TAG_W-1:0]    rd_q, rd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                neg_q, neg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [TAG_W-1:0]    rd_out_q, rd_out_d;

  logic                a_signed, b_signed, a_neg, b_neg, neg_in;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_top, div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   mul_next, div_next, mul_full;
  logic [XLEN-1:0]     div_raw, div_fix, fix_res;

  // Operand decode: signedness per op, magnitudes and the sign of the final result.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: begin
        a_signed = 1'b1;
        b_signed = 1'b0;
      end
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
    a_neg = a_signed & rs1_val[XLEN-1];
    b_neg = b_signed & rs2_val[XLEN-1];
    if (a_neg) begin
      a_mag = -rs1_val;
    end else begin
      a_mag = rs1_val;
    end
    if (b_neg) begin
      b_mag = -rs2_val;
    end else begin
      b_mag = rs2_val;
    end
    case (op)
      OP_MULH, OP_DIV:   neg_in = a_neg ^ b_neg;
      OP_MULHSU, OP_REM: neg_in = a_neg;
      default:           neg_in = 1'b0;
    endcase
    div_zero = op[2] & (rs2_val == ZERO);
    div_ovf  = ((op == OP_DIV) | (op == OP_REM)) & (rs1_val == MOST_NEG) & (rs2_val == ONES);
  end

  // One radix-2 step for each algorithm, plus the sign fix and result selection.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : ZERO)};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Partial remainder after the left shift needs one extra bit before the compare.
    div_top  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_top - {1'b0, opnd_q};
    div_ge   = ~div_diff[XLEN];
    if (div_ge) begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {acc_q[2*XLEN-2:0], 1'b0};
    end
    // High-half products must be negated over the full double width.
    if (neg_q) begin
      mul_full = -acc_q;
    end else begin
      mul_full = acc_q;
    end
    if (op_q[1]) begin
      div_raw = acc_q[2*XLEN-1:XLEN];
    end else begin
      div_raw = acc_q[XLEN-1:0];
    end
    if (neg_q) begin
      div_fix = -div_raw;
    end else begin
      div_fix = div_raw;
    end
    if (op_q[2]) begin
      fix_res = div_fix;
    end else if (op_q == OP_MUL) begin
      fix_res = mul_full[XLEN-1:0];
    end else begin
      fix_res = mul_full[2*XLEN-1:XLEN];
    end
  end

  // Next-state and next-register computation for the control FSM.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    op_d      = op_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d      = op;
          rd_d      = rd_in;
          counter_d = {CNT_W{1'b0}};
          opnd_d    = a_mag;
          neg_d     = neg_in;
          if (div_zero) begin
            acc_d   = {rs1_val, ONES};
            neg_d   = 1'b0;
            state_d = S_FIXUP;
          end else if (div_ovf) begin
            acc_d   = {ZERO, rs1_val};
            neg_d   = 1'b0;
            state_d = S_FIXUP;
          end else if (op[2]) begin
            acc_d   = {ZERO, a_mag};
            opnd_d  = b_mag;
            state_d = S_CALC;
          end else begin
            acc_d   = {ZERO, b_mag};
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          if (counter_q == CNT_LAST) begin
            counter_d = {CNT_W{1'b0}};
            state_d   = S_FIXUP;
          end else begin
            counter_d = counter_q + CNT_ONE;
          end
        end
      end
      S_FIXUP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          rd_out_d = rd_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_FIXUP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      counter_q <= {CNT_W{1'b0}};
      op_q      <= 3'b000;
      rd_q      <= {TAG_W{1'b0}};
      acc_q     <= {(2*XLEN){1'b0}};
      opnd_q    <= ZERO;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= ZERO;
      rd_out_q  <= {TAG_W{1'b0}};
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  // Stall is combinational so the accepting cycle already freezes the pipeline.
  assign stall_req = ((state_q == S_IDLE) && start && !flush) ||
                     (state_q == S_CALC) || (state_q == S_FIXUP);
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus per-cycle output compare.
module tb_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic              flush   = 1'b0;
  logic              start   = 1'b0;
  logic [2:0]        op      = 3'b000;
  logic [XLEN-1:0]   rs1_val = 32'h0;
  logic [XLEN-1:0]   rs2_val = 32'h0;
  logic [TAG_W-1:0]  rd_in   = 5'd0;
  logic              busy, stall_req, done;
  logic [XLEN-1:0]   result;
  logic [TAG_W-1:0]  rd_out;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_on = 1'b0;
  int   accept_at = -1;
  int   done_at = -1;
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   prev_done = -1;
  int   last_done = -1;
  int   c0;
  logic [31:0] exp_res = 32'h0;
  logic [31:0] cur_res = 32'h0;
  logic [4:0]  exp_rd  = 5'd0;
  logic [4:0]  cur_rd  = 5'd0;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .start     (start),
    .op        (op),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_in     (rd_in),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
    end
  endtask

  // Architectural result of an M-extension op, from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'sd0;
    case (o)
      3'b000, 3'b001: p = sa * sb;
      3'b010:         p = sa * ub;
      3'b011:         p = ua * ub;
      3'b100:         p = (b == 32'h0) ? -64'sd1 : (ovf ? sa : sa / sb);
      3'b101:         p = (b == 32'h0) ? -64'sd1 : ua / ub;
      3'b110:         p = (b == 32'h0) ? sa : (ovf ? 64'sd0 : sa % sb);
      default:        p = (b == 32'h0) ? ua : ua % ub;
    endcase
    if (o == 3'b001 || o == 3'b010 || o == 3'b011) return p[63:32];
    return p[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 32'h0) return 1'b1;
    if ((o == 3'b100 || o == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // Per-cycle compare of every output against the expected timeline.
  always @(negedge clk) begin
    if (chk_on) begin
      if (cyc == done_at) begin
        cur_res = exp_res;
        cur_rd  = exp_rd;
      end
      chk("done", 32'(done), 32'(cyc == done_at));
      chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      chk("stall_req", 32'(stall_req), 32'((cyc >= busy_lo && cyc <= busy_hi) || cyc == accept_at));
      chk("result", result, cur_res);
      chk("rd_out", 32'(rd_out), 32'(cur_rd));
      if (done === 1'b1) begin
        prev_done = last_done;
        last_done = cyc;
      end
    end
  end

  // Drive an op in the current cycle (caller is just past a rising edge).
  task automatic begin_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    flush     = 1'b0;
    start     = 1'b1;
    op        = o;
    rs1_val   = a;
    rs2_val   = b;
    rd_in     = rd;
    accept_at = cyc;
    done_at   = cyc + (is_special(o, a, b) ? 2 : XLEN + 2);
    busy_lo   = cyc + 1;
    busy_hi   = done_at - 1;
    exp_res   = model(o, a, b);
    exp_rd    = rd;
  endtask

  task automatic finish_op(input bit hold, input logic [31:0] lit, input string name);
    int n;
    @(posedge clk); #1;
    if (!hold) begin
      start   = 1'b0;
      op      = 3'($urandom);
      rs1_val = $urandom;
      rs2_val = $urandom;
      rd_in   = 5'($urandom);
    end
    n = 0;
    while (cyc < done_at && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_reached", 32'(cyc), 32'(done_at));
    @(negedge clk);
    chk(name, result, lit);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit hold, input logic [31:0] lit, input string name);
    @(posedge clk); #1;
    begin_op(o, a, b, rd);
    finish_op(hold, lit, name);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_on = 1'b1;

    do_op(3'b000, 32'd7,          32'hFFFF_FFF9, 5'd3,  1'b0, 32'hFFFF_FFCF, "mul_7_m7");
    chk("mul_rd", 32'(rd_out), 32'd3);
    do_op(3'b001, 32'h8000_0000,  32'h8000_0000, 5'd4,  1'b0, 32'h4000_0000, "mulh");
    do_op(3'b011, 32'h8000_0000,  32'h8000_0000, 5'd5,  1'b0, 32'h4000_0000, "mulhu");
    do_op(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  1'b0, 32'hFFFF_FFFF, "mulhsu");
    do_op(3'b001, 32'hFFFF_FFFF,  32'd2,         5'd7,  1'b0, 32'hFFFF_FFFF, "mulh_m1x2");
    do_op(3'b100, 32'hFFFF_FFF9,  32'd2,         5'd8,  1'b0, 32'hFFFF_FFFD, "div_m7_2");
    do_op(3'b110, 32'hFFFF_FFF9,  32'd2,         5'd9,  1'b0, 32'hFFFF_FFFF, "rem_m7_2");
    do_op(3'b110, 32'd7,          32'hFFFF_FFFE, 5'd10, 1'b0, 32'd1,         "rem_7_m2");
    do_op(3'b101, 32'd100,        32'd7,         5'd11, 1'b0, 32'd14,        "divu_100_7");
    do_op(3'b111, 32'd100,        32'd7,         5'd12, 1'b0, 32'd2,         "remu_100_7");
    do_op(3'b101, 32'd5,          32'd0,         5'd13, 1'b0, 32'hFFFF_FFFF, "divu_by0");
    do_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1'b0, 32'h8000_0000, "div_ovf");
    do_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 1'b0, 32'd0,         "rem_ovf");
    do_op(3'b100, 32'hFFFF_FFF9,  32'd0,         5'd16, 1'b0, 32'hFFFF_FFFF, "div_by0");
    do_op(3'b110, 32'hFFFF_FFF9,  32'd0,         5'd17, 1'b0, 32'hFFFF_FFF9, "rem_by0");
    do_op(3'b111, 32'd5,          32'd0,         5'd18, 1'b0, 32'd5,         "remu_by0");

    // Flush ten cycles into a divide, then start a multiply straight away.
    @(posedge clk); #1;
    begin_op(3'b100, 32'd1000, 32'd7, 5'd19);
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c0 + 10) begin
      @(posedge clk); #1;
    end
    flush   = 1'b1;
    done_at = -1;
    busy_hi = cyc;
    @(posedge clk); #1;
    begin_op(3'b000, 32'd3, 32'd4, 5'd20);
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_hold", result, 32'd5);
    finish_op(1'b0, 32'd12, "mul_after_flush");

    // Back-to-back with start held through DONE.
    do_op(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd21, 1'b1, 32'h2345_6780, "b2b_mul");
    do_op(3'b101, 32'd1000,      32'd10,         5'd22, 1'b0, 32'd100,       "b2b_divu");
    @(posedge clk); #1;
    chk("b2b_gap", 32'(last_done - prev_done), 32'd35);

    // Reset in the middle of a calculation.
    @(posedge clk); #1;
    begin_op(3'b000, 32'd55, 32'd3, 5'd23);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    accept_at = -1;
    done_at   = -1;
    busy_lo   = 1;
    busy_hi   = 0;
    cur_res   = 32'h0;
    cur_rd    = 5'd0;
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    do_op(3'b000, 32'd5, 32'd6, 5'd24, 1'b0, 32'd30, "mul_after_reset");
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
